// File: rtl/ram_audio_pkg.sv
// Shared types for the audio record/playback sequencer.
package ram_audio_pkg;

  localparam int LED_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SET   = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_WR_PULSE = 3'd3,
    S_RD_SET   = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_RD_DATA  = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_REC  = 2'd1,
    MODE_PLY  = 2'd2
  } mode_e;

  // Exactly one request selects a mode; both or neither means no operation.
  function automatic mode_e decode_mode(input logic rec_req, input logic ply_req);
    if (rec_req && !ply_req) return MODE_REC;
    if (ply_req && !rec_req) return MODE_PLY;
    return MODE_NONE;
  endfunction

endpackage

// File: rtl/ram_audio_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module ram_audio_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins, increment stops at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_audio_ctrl.sv
// Record/playback sequencer between the codec sample strobe and a RAM port.
// Records samples into [addr_start, addr_end), remembers how far it got,
// and plays back with a read request / ack handshake, counting underruns.
// Optional build macro RAM_AUDIO_LOOP_EN: playback wraps to addr_start at the
// region limit instead of finishing.
module ram_audio_ctrl
  import ram_audio_pkg::*;
#(
  parameter int                ADDR_W    = 26,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1),
  parameter int                UNDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_rdy,
  input  logic              audio_rdy,
  input  logic              record,
  input  logic              play,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_end,
  input  logic [DATA_W-1:0] rec_sample,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              write_enb,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_req,
  output logic              read_ack,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] play_sample,
  output logic              busy,
  output logic              done,
  output logic [UNDR_W-1:0] underrun_cnt,
  output logic [LED_W-1:0]  leds
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;     // mode that started the current operation
  mode_e               mode_in;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   lim_q, lim_d;
  logic [ADDR_W-1:0]   rec_end_q, rec_end_d;
  logic                rec_len_vld_q, rec_len_vld_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   play_sample_q, play_sample_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic                write_enb_q, write_enb_d;
  logic                read_req_q, read_req_d;
  logic                read_ack_q, read_ack_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                undr_inc;

  assign mode_in = decode_mode(record, play);

  // Next state and next outputs; strobes default low so they last one cycle.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    addr_d        = addr_q;
    lim_d         = lim_q;
    rec_end_d     = rec_end_q;
    rec_len_vld_d = rec_len_vld_q;
    wr_data_d     = wr_data_q;
    play_sample_d = play_sample_q;
    leds_d        = leds_q;
    write_enb_d   = 1'b0;
    read_req_d    = 1'b0;
    read_ack_d    = 1'b0;
    undr_inc      = 1'b0;
    // RAM not ready: everything holds and the strobes stay low.
    if (ram_rdy) begin
      if (state_q != S_IDLE && mode_in != mode_q) begin
        // Mode dropped or changed: abandon the operation, including any
        // outstanding read, without acknowledging it.
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (mode_in == MODE_REC) begin
              state_d = S_WR_SET;
              mode_d  = MODE_REC;
            end else if (mode_in == MODE_PLY) begin
              state_d = S_RD_SET;
              mode_d  = MODE_PLY;
            end
          end
          S_WR_SET: begin
            addr_d  = addr_start;
            lim_d   = addr_end;
            state_d = S_WR_WAIT;
          end
          S_WR_WAIT: begin
            if (addr_q >= lim_q) begin
              state_d = S_DONE;
            end else if (audio_rdy) begin
              write_enb_d = 1'b1;
              wr_data_d   = rec_sample;
              state_d     = S_WR_PULSE;
            end
          end
          S_WR_PULSE: begin
            // Address moves only after the strobe cycle so it is stable with write_enb.
            addr_d        = addr_q + ADDR_STEP;
            leds_d        = addr_q[LED_W-1:0];
            rec_end_d     = addr_q + ADDR_STEP;
            rec_len_vld_d = 1'b1;
            state_d       = S_WR_WAIT;
          end
          S_RD_SET: begin
            addr_d  = addr_start;
            lim_d   = rec_len_vld_q ? rec_end_q : addr_end;
            state_d = S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (addr_q >= lim_q) begin
`ifdef RAM_AUDIO_LOOP_EN
              addr_d  = addr_start;
`else
              state_d = S_DONE;
`endif
            end else if (audio_rdy) begin
              read_req_d = 1'b1;
              state_d    = S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            // A strobe while still waiting for data is lost and only counted.
            if (audio_rdy) undr_inc = 1'b1;
            if (rd_valid) begin
              play_sample_d = rd_data;
              read_ack_d    = 1'b1;
              addr_d        = addr_q + ADDR_STEP;
              leds_d        = addr_q[LED_W-1:0];
              state_d       = S_RD_WAIT;
            end
          end
          S_DONE: begin
            state_d = S_DONE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_NONE;
      addr_q        <= '0;
      lim_q         <= '0;
      rec_end_q     <= '0;
      rec_len_vld_q <= 1'b0;
      wr_data_q     <= '0;
      play_sample_q <= '0;
      leds_q        <= '0;
      write_enb_q   <= 1'b0;
      read_req_q    <= 1'b0;
      read_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      addr_q        <= addr_d;
      lim_q         <= lim_d;
      rec_end_q     <= rec_end_d;
      rec_len_vld_q <= rec_len_vld_d;
      wr_data_q     <= wr_data_d;
      play_sample_q <= play_sample_d;
      leds_q        <= leds_d;
      write_enb_q   <= write_enb_d;
      read_req_q    <= read_req_d;
      read_ack_q    <= read_ack_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  ram_audio_sat_cnt #(
    .WIDTH (UNDR_W)
  ) u_undr_cnt (
    .clk_i (clk),
    .clr_i (reset),
    .inc_i (undr_inc),
    .cnt_o (underrun_cnt)
  );

  assign write_enb   = write_enb_q;
  assign wr_data     = wr_data_q;
  assign read_req    = read_req_q;
  assign read_ack    = read_ack_q;
  assign addr        = addr_q;
  assign play_sample = play_sample_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_ram_audio_ctrl.sv
// Directed-plus-random bench for ram_audio_ctrl with a simple external RAM model.
module tb_ram_audio_ctrl;

  localparam int ADDR_W   = 26;
  localparam int DATA_W   = 16;
  localparam int UNDR_W   = 8;
  localparam int UNDR_MAX = (1 << UNDR_W) - 1;
`ifdef RAM_AUDIO_LOOP_EN
  localparam int LOOP = 1;
`else
  localparam int LOOP = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, ram_rdy, audio_rdy, record, play, rd_valid;
  logic [ADDR_W-1:0] addr_start, addr_end;
  logic [DATA_W-1:0] rec_sample, rd_data;
  logic              write_enb, read_req, read_ack, busy, done;
  logic [DATA_W-1:0] wr_data, play_sample;
  logic [ADDR_W-1:0] addr;
  logic [UNDR_W-1:0] underrun_cnt;
  logic [7:0]        leds;

  int n_chk = 0;
  int n_err = 0;

  // RAM model state and observation logs
  logic [DATA_W-1:0] mem [0:255];
  logic [ADDR_W-1:0] wr_a [$];
  logic [DATA_W-1:0] wr_d [$];
  int                n_req = 0, n_ack = 0;
  int                rd_lat = 0, rd_cnt = 0;
  bit                rd_pend = 1'b0;
  logic [7:0]        rd_a = '0;

  ram_audio_ctrl dut (
    .clk(clk), .reset(reset), .ram_rdy(ram_rdy), .audio_rdy(audio_rdy),
    .record(record), .play(play), .addr_start(addr_start), .addr_end(addr_end),
    .rec_sample(rec_sample), .rd_valid(rd_valid), .rd_data(rd_data),
    .write_enb(write_enb), .wr_data(wr_data), .read_req(read_req), .read_ack(read_ack),
    .addr(addr), .play_sample(play_sample), .busy(busy), .done(done),
    .underrun_cnt(underrun_cnt), .leds(leds)
  );

  always #5 clk = ~clk;

  // External RAM: stores writes, answers each read after rd_lat cycles.
  always @(negedge clk) begin
    rd_valid = 1'b0;
    if (write_enb) begin
      mem[addr[7:0]] = wr_data;
      wr_a.push_back(addr);
      wr_d.push_back(wr_data);
    end
    if (read_ack) n_ack++;
    if (read_req) begin
      n_req++;
      rd_pend = 1'b1;
      rd_cnt  = rd_lat;
      rd_a    = addr[7:0];
    end
    if (rd_pend) begin
      if (rd_cnt == 0) begin
        rd_valid = 1'b1;
        rd_data  = mem[rd_a];
        rd_pend  = 1'b0;
      end else begin
        rd_cnt--;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int t = 0; t < 12; t++) begin
      step();
      if (read_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {write_enb, read_req, read_ack, busy, done, underrun_cnt, leds}, 64'd0);
    chk({tag, "_dat"}, {addr, wr_data, play_sample}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] samp [0:5];
    bit got;
    int ur, n0, nexp;
    logic [DATA_W-1:0] pat [0:1];

    for (int i = 0; i < 256; i++) mem[i] = '0;
    pat[0] = 16'hA5A5;
    pat[1] = 16'h5A5A;
    mem[0] = pat[0];
    mem[1] = pat[1];
    reset = 1'b1; ram_rdy = 1'b1; audio_rdy = 1'b0; record = 1'b0; play = 1'b0;
    addr_start = '0; addr_end = '0; rec_sample = '0;
    step(2);
    chk_zero("reset");
    reset = 1'b0;

    // ---- record 0x10..0x14 with 6 strobes
    addr_start = 26'h10; addr_end = 26'h14; record = 1'b1;
    step(2);
    chk("rec_busy", busy, 1);
    chk("rec_base", addr, 26'h10);
    for (int i = 0; i < 6; i++) begin
      samp[i] = DATA_W'($urandom);
      rec_sample = samp[i];
      audio_rdy = 1'b1;
      step();
      audio_rdy = 1'b0;
      chk($sformatf("rec_we%0d", i), write_enb, (i < 4) ? 1 : 0);
      if (i < 4) begin
        chk($sformatf("rec_addr%0d", i), addr, 26'h10 + i);
        chk($sformatf("rec_wdat%0d", i), wr_data, samp[i]);
      end
      step($urandom_range(1, 3));
    end
    step();
    chk("rec_done", done, 1);
    chk("rec_idle_busy", busy, 0);
    chk("rec_leds", leds, 8'h13);
    chk("rec_nwr", wr_a.size(), 4);
    for (int k = 0; k < 4 && k < wr_a.size(); k++) begin
      chk($sformatf("rec_log_a%0d", k), wr_a[k], 26'h10 + k);
      chk($sformatf("rec_log_d%0d", k), wr_d[k], samp[k]);
    end
    record = 1'b0;
    step();
    chk("rec_release", {busy, done}, 2'b00);

    // ---- play back; recorded length limits the region, not addr_end
    addr_end = 26'h20; play = 1'b1;
    step(2);
    for (int i = 0; i < 6; i++) begin
      rd_lat = $urandom_range(0, 2);
      audio_rdy = 1'b1;
      step();
      audio_rdy = 1'b0;
      chk($sformatf("ply_req%0d", i), read_req, (i < 4) ? 1 : 0);
      if (i < 4) begin
        chk($sformatf("ply_addr%0d", i), addr, 26'h10 + i);
        wait_ack(got);
        chk($sformatf("ply_ack%0d", i), got, 1);
        chk($sformatf("ply_smp%0d", i), play_sample, samp[i]);
        chk($sformatf("ply_leds%0d", i), leds, 8'h10 + i);
      end
      step($urandom_range(1, 2));
    end
    chk("ply_done", done, 1);
    chk("ply_no_undr", underrun_cnt, 0);
    play = 1'b0;
    step();

    // ---- underruns: one during a slow read, then 300 more to saturate
    play = 1'b1;
    step(2);
    rd_lat = 5;
    audio_rdy = 1'b1;
    step();
    audio_rdy = 1'b0;
    chk("ur_req", read_req, 1);
    step();
    audio_rdy = 1'b1;
    step();
    audio_rdy = 1'b0;
    wait_ack(got);
    chk("ur_ack", got, 1);
    chk("ur_one", underrun_cnt, 1);
    chk("ur_smp", play_sample, samp[0]);
    rd_lat = 1000;
    step();
    audio_rdy = 1'b1;
    step();
    chk("ur_req2", read_req, 1);
    ur = 1;
    for (int k = 0; k < 300; k++) begin
      step();
      ur = (ur < UNDR_MAX) ? ur + 1 : UNDR_MAX;
      chk($sformatf("ur_cnt%0d", k), underrun_cnt, ur);
    end
    audio_rdy = 1'b0;
    n0 = n_ack;
    play = 1'b0;
    step();
    chk("drop_idle", {busy, done}, 2'b00);
    step(4);
    chk("drop_no_ack", n_ack, n0);
    chk("ur_sat_hold", underrun_cnt, UNDR_MAX);

    // ---- conflicting modes mid-record
    addr_start = 26'h40; addr_end = 26'h48; record = 1'b1;
    step(2);
    rec_sample = 16'h1234;
    audio_rdy = 1'b1;
    step();
    audio_rdy = 1'b0;
    chk("both_we", write_enb, 1);
    play = 1'b1;
    step();
    chk("both_we_off", write_enb, 0);
    chk("both_idle", {busy, done}, 2'b00);
    record = 1'b0; play = 1'b0;
    step();

    // ---- reset while the write strobe is out
    record = 1'b1;
    step(2);
    audio_rdy = 1'b1;
    step();
    audio_rdy = 1'b0;
    chk("rstp_we", write_enb, 1);
    reset = 1'b1;
    step();
    chk_zero("rst_pulse");
    reset = 1'b0; record = 1'b0;
    step();

    // ---- empty region records nothing
    n0 = wr_a.size();
    addr_start = 26'h8; addr_end = 26'h8; record = 1'b1;
    step(3);
    chk("empty_done", done, 1);
    step();
    chk("empty_nwr", wr_a.size(), n0);
    record = 1'b0;
    step();

`ifndef RAM_AUDIO_LOOP_EN
    // ---- reversed region plays nothing even with strobes present
    n0 = n_req;
    addr_start = 26'h30; addr_end = 26'h20; play = 1'b1; audio_rdy = 1'b1;
    step(3);
    audio_rdy = 1'b0;
    chk("rev_done", done, 1);
    step();
    chk("rev_nreq", n_req, n0);
    play = 1'b0;
    step();
`endif

    // ---- region 0..2 playback: wraps with the loop option, else finishes
    nexp = (LOOP != 0) ? 6 : 2;
    addr_start = 26'h0; addr_end = 26'h2; play = 1'b1;
    step(2);
    for (int k = 0; k < 6; k++) begin
      rd_lat = $urandom_range(0, 2);
      audio_rdy = 1'b1;
      step();
      audio_rdy = 1'b0;
      chk($sformatf("loop_req%0d", k), read_req, (k < nexp) ? 1 : 0);
      if (k < nexp) begin
        chk($sformatf("loop_addr%0d", k), addr, k % 2);
        wait_ack(got);
        chk($sformatf("loop_ack%0d", k), got, 1);
        chk($sformatf("loop_smp%0d", k), play_sample, pat[k % 2]);
      end
      step(3);
    end
    chk("loop_done", done, (LOOP != 0) ? 0 : 1);
    // freeze: strobes ignored, address held
    ram_rdy = 1'b0;
    audio_rdy = 1'b1;
    step();
    audio_rdy = 1'b0;
    chk("frz_ply_req", read_req, 0);
    step(2);
    chk("frz_ply_addr", addr, (LOOP != 0) ? 0 : 2);
    ram_rdy = 1'b1;
    play = 1'b0;
    step();

    // ---- freeze during record, then resume
    addr_start = 26'h50; addr_end = 26'h58; record = 1'b1;
    step(2);
    ram_rdy = 1'b0;
    audio_rdy = 1'b1;
    step();
    audio_rdy = 1'b0;
    chk("frz_we", write_enb, 0);
    step(2);
    chk("frz_addr", addr, 26'h50);
    chk("frz_busy", busy, 1);
    ram_rdy = 1'b1;
    rec_sample = 16'hBEEF;
    audio_rdy = 1'b1;
    step();
    audio_rdy = 1'b0;
    chk("res_we", write_enb, 1);
    chk("res_addr", addr, 26'h50);
    chk("res_wdat", wr_data, 16'hBEEF);
    step();
    record = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
